// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked RV32I/RV32M execute ALU with iterative shift-add multiplier
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_illegal
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;
    logic              valid_q, zero_q, neg_q, illegal_q;

    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [SW-1:0]     count_q;
    logic              mneg_q, mhi_q;
    logic [TAG_W-1:0]  mtag_q;

    logic              out_free, accept, is_alu_op, is_mul_op, op_mulh;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   alu_res, a_abs, b_abs;
    logic [2*XLEN-1:0] acc_step;
    logic              mul_last;

    logic              out_load;
    logic [XLEN-1:0]   ld_res;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_ill;
    logic              valid_d;

    // Product magnitude is unsigned; MULH restores the sign by negating the full 2*XLEN value.
    function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] acc,
                                                   input logic neg, input logic hi);
        logic [2*XLEN-1:0] p;
        p = neg ? -acc : acc;
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    assign out_free = !valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign shamt    = in_b[SW-1:0];
    assign op_mulh  = (in_op == 5'b10001);
    assign a_abs    = in_a[XLEN-1] ? -in_a : in_a;
    assign b_abs    = in_b[XLEN-1] ? -in_b : in_b;
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_last = (count_q == SW'(XLEN - 1));

    // Opcode decode: base ALU codes and (optionally) the three multiply codes.
    always_comb begin
        is_alu_op = 1'b0;
        case (in_op)
            5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b00111: is_alu_op = 1'b1;
            default: is_alu_op = 1'b0;
        endcase
        is_mul_op = (MUL_EN != 0) &&
                    ((in_op == 5'b10000) || (in_op == 5'b10001) || (in_op == 5'b10011));
    end

    // Single-cycle ALU datapath.
    always_comb begin
        alu_res = '0;
        case (in_op)
            5'b00000: alu_res = in_a + in_b;
            5'b01000: alu_res = in_a - in_b;
            5'b00001: alu_res = in_a << shamt;
            5'b00010: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            5'b00011: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            5'b00100: alu_res = in_a ^ in_b;
            5'b00101: alu_res = in_a >> shamt;
            5'b01101: alu_res = $unsigned($signed(in_a) >>> shamt);
            5'b00110: alu_res = in_a | in_b;
            5'b00111: alu_res = in_a & in_b;
            default:  alu_res = '0;
        endcase
    end

    // Next state and output-register load selection.
    always_comb begin
        state_d  = state_q;
        out_load = 1'b0;
        ld_res   = '0;
        ld_tag   = in_tag;
        ld_ill   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_d = MUL;
                    end else begin
                        out_load = 1'b1;
                        ld_res   = is_alu_op ? alu_res : '0;
                        ld_ill   = !is_alu_op;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    if (out_free) begin
                        out_load = 1'b1;
                        ld_res   = mul_select(acc_step, mneg_q, mhi_q);
                        ld_tag   = mtag_q;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_free) begin
                    out_load = 1'b1;
                    ld_res   = mul_select(acc_q, mneg_q, mhi_q);
                    ld_tag   = mtag_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (out_load)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
        else               valid_d = valid_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Multiplier: latch operands on accept, then one shift-add step per cycle while in MUL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            mneg_q   <= 1'b0;
            mhi_q    <= 1'b0;
            mtag_q   <= '0;
        end else if (state_q == IDLE && accept && is_mul_op) begin
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, (op_mulh ? a_abs : in_a)};
            mplier_q <= op_mulh ? b_abs : in_b;
            count_q  <= '0;
            mneg_q   <= op_mulh && (in_a[XLEN-1] ^ in_b[XLEN-1]);
            mhi_q    <= in_op[0];
            mtag_q   <= in_tag;
        end else if (state_q == MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
        end
    end

    // Output register: result, tag and flags always load together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (out_load) begin
                result_q  <= ld_res;
                tag_q     <= ld_tag;
                zero_q    <= (ld_res == '0);
                neg_q     <= ld_res[XLEN-1];
                illegal_q <= ld_ill;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_tag     = tag_q;
    assign out_zero    = zero_q;
    assign out_neg     = neg_q;
    assign out_illegal = illegal_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU, sitting between decode/operand-fetch and writeback.
- Performs the RV32I register/immediate ALU operations with correct signed semantics and a 1-cycle registered latency.
- When MUL_EN=1, also performs the RV32M MUL/MULH/MULHU operations with an iterative shift-add multiplier.
- Valid/ready on both sides; a tag is passed through so writeback can match each result to its destination register.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- TAG_W, 5, width of the pass-through tag (destination register index).
- MUL_EN, 1, 1 enables the multiply ops; 0 makes them illegal.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- in_valid  input  1  operation presented
- in_ready  output  1  operation accepted this cycle when high together with in_valid
- in_op  input  5  {m_ext, funct7[5], funct3}
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- in_tag  input  TAG_W  tag
- out_valid  output  1  result register valid
- out_ready  input  1  consumer accepts the result
- out_result  output  XLEN  result
- out_tag  output  TAG_W  tag of the result
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[XLEN-1]
- out_illegal  output  1  in_op was not a defined code

Behaviour:
- reset is asynchronous and active-high; clock is clk, all state updates on its rising edge.
- On reset: out_valid=0, out_result=0, out_tag=0, out_zero=0, out_neg=0, out_illegal=0, FSM=IDLE, multiplier state cleared.
  - Reset during a multiply aborts it; no result is produced.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready). It is purely combinational, so in_ready=1 immediately after reset.
- Accept means in_valid && in_ready at a rising edge. Inputs are don't-care when not accepted.
- Output register:
  - out_valid clears on the edge where out_valid && out_ready, unless a new result is loaded on that same edge, in which case it stays 1.
  - Output contents are stable while out_valid && !out_ready.
- Opcodes (m_ext=0):
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA (arithmetic), 0110 OR, 0111 AND.
  - Shift amount is in_b[log2(XLEN)-1:0]; upper bits are ignored.
  - Add/sub wrap modulo 2^XLEN.
  - SLT/SLTU produce 1 or 0, zero-extended.
- Single-cycle ops: the result is loaded on the accepting edge; out_valid is high in the following cycle (latency 1).
- Opcodes (m_ext=1, only when MUL_EN=1):
  - 10000 MUL: low XLEN bits of the product.
  - 10001 MULH: high XLEN bits of signed×signed.
  - 10011 MULHU: high XLEN bits of unsigned×unsigned.
- Illegal: every other code, including all m_ext=1 codes when MUL_EN=0.
  - Behaves as a single-cycle op: out_result=0, out_illegal=1, out_zero=1, out_neg=0.
- Flags and tag are loaded together with the result they describe; a flag never lags its result.
- FSM states: IDLE, MUL, DONE.
  - IDLE→MUL: on accepting a multiply. Latch operand magnitudes (MULH: absolute values plus result sign = a_sign XOR b_sign), tag, and op; clear the 2·XLEN accumulator; count=0.
  - MUL: one shift-add step per cycle; count increments. After the XLEN-th step (count==XLEN-1):
    - If the output register is free (!out_valid || out_ready), load the sign-corrected result and go to IDLE.
    - Otherwise go to DONE.
  - DONE: hold the product; load it on the first edge where the output is free, then go to IDLE.
  - Unstalled multiply latency: accepted on edge 0, out_valid high after edge XLEN.
- Signed MULH corner: (-2^(XLEN-1))×(-2^(XLEN-1)) gives a high word of 2^(XLEN-2), with no overflow handling needed beyond 2·XLEN width.
- Back-to-back single-cycle ops with out_ready=1 sustain one op per cycle. An op presented in the cycle a multiply completes is accepted only once the FSM is back in IDLE.

Test Plan:
- Reset mid-multiply: assert reset 5 cycles after accepting MUL → out_valid=0, in_ready=1 the cycle after release; no stray result later.
- Back-to-back ops, out_ready=1:
  - ADD 7,5 tag 3 → 12, tag 3, zero 0.
  - SUB 5,5 → 0, zero 1.
  - SRA 0x80000000,0x24 → 0xF8000000 (shift amount 4), neg 1.
  - SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0.
  - All issued one per cycle.
- Backpressure: out_ready=0 for 3 cycles after an XOR result → in_ready=0 and out_result stable throughout; release → the next queued op is accepted on the same edge the XOR result is consumed.
- MULH 0xFFFFFFFF(-1),0x00000002 → 0xFFFFFFFF; MUL same operands → 0xFFFFFFFE; MULHU 0xFFFFFFFF,0xFFFFFFFF → 0xFFFFFFFE. Each result has out_valid exactly 32 cycles after accept.
- Multiply completes while the output is stalled → FSM holds in DONE; the product appears on the first edge with out_ready=1; tag is preserved.
- Illegal op 11110 → result 0, illegal 1, latency 1. With MUL_EN=0, op 10000 → illegal 1.
